// File: rtl/lzc_norm_arbiter_if.sv
// lzc_norm_arbiter_if: request/response bundle between requesters, consumer and the shared normaliser.
interface lzc_norm_arbiter_if #(
    parameter int W    = 22,
    parameter int NREQ = 2,
    parameter int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [TAGW-1:0]   resp_tag;
    logic              resp_sign;
    logic [W-1:0]      resp_mant;
    logic [4:0]        resp_shift;
    logic              resp_zero;
    logic              busy;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_tag, resp_sign, resp_mant, resp_shift, resp_zero, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_tag, resp_sign, resp_mant, resp_shift, resp_zero, busy
    );
endinterface

// File: rtl/lzc_norm_arbiter.sv
// lzc_norm_arbiter: round-robin share of one leading-zero counter and normalising shifter.
// Returns sign, normalised magnitude, shift count and zero flag, tagged by requester.
module lzc_norm_arbiter #(
    parameter int W    = 22,
    parameter int NREQ = 2,
    parameter int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic               clk,
    input logic               rst_n,
    lzc_norm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, SHIFT, RESP} state_t;

    state_t          state;
    logic [TAGW-1:0] rr_ptr;
    logic [TAGW-1:0] gnt;
    logic [TAGW-1:0] g_q;
    logic            any_req;
    logic [W-1:0]    data_q;
    logic [W-1:0]    mag;
    logic [W-1:0]    mag_q;
    logic [4:0]      lzc_q;
    logic            sign_q;

    function automatic logic [TAGW-1:0] wrap(input int i);
        return TAGW'(i >= NREQ ? i - NREQ : i);
    endfunction

    // Highest set bit wins because the scan runs upward; zero leaves the count at W.
    function automatic logic [4:0] lzc(input logic [W-1:0] v);
        lzc = 5'(W);
        for (int i = 0; i < W; i++)
            if (v[i]) lzc = 5'(W - 1 - i);
    endfunction

    always_comb begin
        gnt     = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap(int'(rr_ptr) + k)]) begin
                gnt     = wrap(int'(rr_ptr) + k);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && any_req)
            bus.req_ready[gnt] = 1'b1;
    end

    // Two's-complement negate; the most-negative value maps onto itself, which is the correct unsigned magnitude.
    assign mag = sign_q ? -data_q : data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            g_q            <= '0;
            data_q         <= '0;
            sign_q         <= 1'b0;
            mag_q          <= '0;
            lzc_q          <= '0;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_tag   <= '0;
            bus.resp_sign  <= 1'b0;
            bus.resp_mant  <= '0;
            bus.resp_shift <= '0;
            bus.resp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    g_q      <= gnt;
                    data_q   <= bus.req_data[int'(gnt) * W +: W];
                    sign_q   <= bus.req_data[int'(gnt) * W + W - 1];
                    bus.busy <= 1'b1;
                    state    <= CALC;
                end
                CALC: begin
                    mag_q <= mag;
                    lzc_q <= lzc(mag);
                    state <= SHIFT;
                end
                SHIFT: begin
                    bus.resp_mant  <= mag_q << lzc_q;
                    bus.resp_shift <= lzc_q;
                    bus.resp_zero  <= mag_q == '0;
                    bus.resp_tag   <= g_q;
                    bus.resp_sign  <= sign_q;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                    rr_ptr         <= wrap(int'(g_q) + 1);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
